// File: rtl/data_register_bank_pkg.sv
// rtl/data_register_bank_pkg.sv - shared defaults and output-select bit positions for the register bank
package data_register_bank_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned PC_RESET_DEF   = 0;

  // Bit positions inside the one-hot output select vector
  localparam int unsigned OUT_AR      = 0;
  localparam int unsigned OUT_DR_BASE = 1;

  // The PC select bit sits just above the last DR bit
  function automatic int unsigned out_pc_bit(input int unsigned num_dr);
    return num_dr + 1;
  endfunction

endpackage

// File: rtl/data_register_bank_if.sv
// rtl/data_register_bank_if.sv - sequencer/datapath bundle for the register bank
interface data_register_bank_if
  import data_register_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_DR     = 4,
  parameter int unsigned IDX_W      = 2
);

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_ar_we;
  logic [NUM_DR-1:0]     i_dr_we;
  logic                  i_pc_we;
  logic                  i_ar_post_inc;
  logic                  i_pc_counter_en;
  logic                  i_stall;
  logic [NUM_DR+1:0]     i_out_en;
  logic [IDX_W-1:0]      i_op0_sel;
  logic [IDX_W-1:0]      i_op1_sel;
  logic                  i_read_addr_source;
  logic                  i_err_clr;

  logic [DATA_WIDTH-1:0] o_direct_addr;
  logic [DATA_WIDTH-1:0] o_operand0;
  logic [DATA_WIDTH-1:0] o_operand1;
  logic [DATA_WIDTH-1:0] o_register_output;
  logic [DATA_WIDTH-1:0] o_mem_read_addr;
  logic [DATA_WIDTH-1:0] o_program_addr;
  logic                  o_err_out_multi;
  logic                  o_err_collision;

  modport master (
    output i_data, i_ar_we, i_dr_we, i_pc_we, i_ar_post_inc, i_pc_counter_en,
    output i_stall, i_out_en, i_op0_sel, i_op1_sel, i_read_addr_source, i_err_clr,
    input  o_direct_addr, o_operand0, o_operand1, o_register_output,
    input  o_mem_read_addr, o_program_addr, o_err_out_multi, o_err_collision
  );

  modport slave (
    input  i_data, i_ar_we, i_dr_we, i_pc_we, i_ar_post_inc, i_pc_counter_en,
    input  i_stall, i_out_en, i_op0_sel, i_op1_sel, i_read_addr_source, i_err_clr,
    output o_direct_addr, o_operand0, o_operand1, o_register_output,
    output o_mem_read_addr, o_program_addr, o_err_out_multi, o_err_collision
  );

endinterface

// File: rtl/data_register_bank_pc_unit.sv
// rtl/data_register_bank_pc_unit.sv - program counter with jump/increment priority and stall
module data_register_bank_pc_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PC_STRIDE  = 1,
  parameter int unsigned PC_RESET   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_we,
  input  logic                  i_inc,
  input  logic                  i_stall,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_collision
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;

  // Jump load beats auto-increment; increment wraps; stall holds the PC
  always_comb begin
    pc_d = pc_q;
    if (!i_stall) begin
      if (i_we) begin
        pc_d = i_data;
      end else if (i_inc) begin
        pc_d = pc_q + DATA_WIDTH'(PC_STRIDE);
      end
    end
  end

  // PC register, reset straight to the boot vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= DATA_WIDTH'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_collision = i_we & i_inc & ~i_stall;

endmodule

// File: rtl/data_register_bank.sv
// rtl/data_register_bank.sv - AR, DR array and PC with operand/address muxing and sticky error flags
module data_register_bank
  import data_register_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_DR     = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned AR_STRIDE  = 1,
  parameter int unsigned PC_STRIDE  = 1,
  parameter int unsigned PC_RESET   = PC_RESET_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  data_register_bank_if.slave bus
);

  localparam int unsigned OUT_PC = out_pc_bit(NUM_DR);
  localparam int unsigned NSEL   = NUM_DR + 2;

  logic [DATA_WIDTH-1:0] ar_q;
  logic [DATA_WIDTH-1:0] ar_d;
  logic [DATA_WIDTH-1:0] dr_q [NUM_DR];
  logic [DATA_WIDTH-1:0] dr_d [NUM_DR];
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] reg_out;
  logic [DATA_WIDTH-1:0] operand0;
  logic [DATA_WIDTH-1:0] operand1;
  logic                  pc_collision;
  logic                  ar_collision;
  logic                  out_multi;
  logic                  err_multi_q;
  logic                  err_multi_d;
  logic                  err_coll_q;
  logic                  err_coll_d;

  data_register_bank_pc_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_STRIDE  (PC_STRIDE),
    .PC_RESET   (PC_RESET)
  ) u_pc_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (bus.i_data),
    .i_we        (bus.i_pc_we),
    .i_inc       (bus.i_pc_counter_en),
    .i_stall     (bus.i_stall),
    .o_pc        (pc),
    .o_collision (pc_collision)
  );

  // AR next value: load beats post-increment, stall freezes
  always_comb begin
    ar_d = ar_q;
    if (!bus.i_stall) begin
      if (bus.i_ar_we) begin
        ar_d = bus.i_data;
      end else if (bus.i_ar_post_inc) begin
        ar_d = ar_q + DATA_WIDTH'(AR_STRIDE);
      end
    end
  end

  // Each DR loads the shared write data on its own enable
  always_comb begin
    for (int k = 0; k < NUM_DR; k++) begin
      dr_d[k] = dr_q[k];
      if (bus.i_dr_we[k] && !bus.i_stall) begin
        dr_d[k] = bus.i_data;
      end
    end
  end

  // Sticky error flags: a new error on the clearing edge keeps the flag set
  always_comb begin
    ar_collision = bus.i_ar_we & bus.i_ar_post_inc & ~bus.i_stall;
    out_multi    = |(bus.i_out_en & (bus.i_out_en - NSEL'(1)));
    err_coll_d   = ar_collision | pc_collision | (err_coll_q & ~bus.i_err_clr);
    err_multi_d  = out_multi | (err_multi_q & ~bus.i_err_clr);
  end

  // AR, DR array and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q        <= '0;
      err_multi_q <= 1'b0;
      err_coll_q  <= 1'b0;
      for (int k = 0; k < NUM_DR; k++) begin
        dr_q[k] <= '0;
      end
    end else begin
      ar_q        <= ar_d;
      err_multi_q <= err_multi_d;
      err_coll_q  <= err_coll_d;
      for (int k = 0; k < NUM_DR; k++) begin
        dr_q[k] <= dr_d[k];
      end
    end
  end

  // OR of every selected register; indices past the DR array read as zero
  always_comb begin
    reg_out = '0;
    if (bus.i_out_en[OUT_AR]) begin
      reg_out = reg_out | ar_q;
    end
    for (int k = 0; k < NUM_DR; k++) begin
      if (bus.i_out_en[OUT_DR_BASE + k]) begin
        reg_out = reg_out | dr_q[k];
      end
    end
    if (bus.i_out_en[OUT_PC]) begin
      reg_out = reg_out | pc;
    end
    operand0 = '0;
    operand1 = '0;
    for (int k = 0; k < NUM_DR; k++) begin
      if (int'(bus.i_op0_sel) == k) begin
        operand0 = dr_q[k];
      end
      if (int'(bus.i_op1_sel) == k) begin
        operand1 = dr_q[k];
      end
    end
  end

  assign bus.o_direct_addr     = ar_q;
  assign bus.o_operand0        = operand0;
  assign bus.o_operand1        = operand1;
  assign bus.o_register_output = reg_out;
  assign bus.o_mem_read_addr   = bus.i_read_addr_source ? pc : ar_q;
  assign bus.o_program_addr    = pc;
  assign bus.o_err_out_multi   = err_multi_q;
  assign bus.o_err_collision   = err_coll_q;

endmodule

// File: tb/tb_data_register_bank.sv
// tb/tb_data_register_bank.sv - randomized bench for the register bank against a behavioural model
module tb_data_register_bank;

  localparam int DW  = 16;
  localparam int NDR = 4;
  localparam int IW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_register_bank_if #(.DATA_WIDTH(DW), .NUM_DR(NDR), .IDX_W(IW)) bus ();

  data_register_bank #(
    .DATA_WIDTH (DW),
    .NUM_DR     (NDR),
    .IDX_W      (IW),
    .AR_STRIDE  (1),
    .PC_STRIDE  (1),
    .PC_RESET   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model state
  logic [DW-1:0] m_ar;
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_dr [NDR];
  logic          m_em;
  logic          m_ec;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ar = '0;
    m_pc = '0;
    for (int k = 0; k < NDR; k++) m_dr[k] = '0;
    m_em = 1'b0;
    m_ec = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.i_data             = '0;
    bus.i_ar_we            = 1'b0;
    bus.i_dr_we            = '0;
    bus.i_pc_we            = 1'b0;
    bus.i_ar_post_inc      = 1'b0;
    bus.i_pc_counter_en    = 1'b0;
    bus.i_stall            = 1'b0;
    bus.i_out_en           = '0;
    bus.i_op0_sel          = '0;
    bus.i_op1_sel          = '0;
    bus.i_read_addr_source = 1'b0;
    bus.i_err_clr          = 1'b0;
  endtask

  // Compare every output with what the model says for the current inputs
  task automatic check_all(input string tag);
    logic [DW-1:0] ro;
    ro = '0;
    if (bus.i_out_en[0]) ro = ro | m_ar;
    for (int k = 0; k < NDR; k++) if (bus.i_out_en[k+1]) ro = ro | m_dr[k];
    if (bus.i_out_en[NDR+1]) ro = ro | m_pc;
    check({tag, ":addr"},  bus.o_direct_addr, m_ar);
    check({tag, ":op0"},   bus.o_operand0, m_dr[bus.i_op0_sel]);
    check({tag, ":op1"},   bus.o_operand1, m_dr[bus.i_op1_sel]);
    check({tag, ":rout"},  bus.o_register_output, ro);
    check({tag, ":mem"},   bus.o_mem_read_addr, bus.i_read_addr_source ? m_pc : m_ar);
    check({tag, ":pc"},    bus.o_program_addr, m_pc);
    check({tag, ":emul"},  bus.o_err_out_multi, m_em);
    check({tag, ":ecol"},  bus.o_err_collision, m_ec);
  endtask

  // Apply the rules of one clock edge to the model
  task automatic model_edge();
    logic coll;
    logic multi;
    coll  = !bus.i_stall && ((bus.i_ar_we && bus.i_ar_post_inc) || (bus.i_pc_we && bus.i_pc_counter_en));
    multi = $countones(bus.i_out_en) > 1;
    if (!bus.i_stall) begin
      if (bus.i_ar_we) m_ar = bus.i_data;
      else if (bus.i_ar_post_inc) m_ar = m_ar + 16'd1;
      if (bus.i_pc_we) m_pc = bus.i_data;
      else if (bus.i_pc_counter_en) m_pc = m_pc + 16'd1;
      for (int k = 0; k < NDR; k++) if (bus.i_dr_we[k]) m_dr[k] = bus.i_data;
    end
    m_ec = coll || (m_ec && !bus.i_err_clr);
    m_em = multi || (m_em && !bus.i_err_clr);
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Pull reset in the middle of a low phase; outputs must react before any edge
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    check("rst:addr0", bus.o_direct_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("init");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset with AR loaded
    bus.i_ar_we = 1'b1; bus.i_data = 16'h1234;
    step("ld_ar");
    clear_inputs();
    #1;
    check("ar_1234", bus.o_direct_addr, 32'h1234);
    mid_reset();

    // Load and operand select
    bus.i_dr_we = 4'b0100; bus.i_data = 16'hBEEF;
    step("ld_dr2");
    bus.i_dr_we = 4'b0001; bus.i_data = 16'h0011;
    step("ld_dr0");
    clear_inputs();
    bus.i_op0_sel = 2'd2; bus.i_op1_sel = 2'd0; bus.i_out_en = 6'b001000;
    #1;
    check("sel_op0", bus.o_operand0, 32'hBEEF);
    check("sel_op1", bus.o_operand1, 32'h0011);
    check("sel_rout", bus.o_register_output, 32'hBEEF);
    step("sel");

    // Wrap of AR and PC
    clear_inputs();
    bus.i_ar_we = 1'b1; bus.i_pc_we = 1'b1; bus.i_data = 16'hFFFF;
    step("ld_ffff");
    clear_inputs();
    bus.i_ar_post_inc = 1'b1; bus.i_pc_counter_en = 1'b1;
    step("wrap");
    clear_inputs();
    #1;
    check("wrap_ar", bus.o_direct_addr, 32'h0);
    check("wrap_pc", bus.o_program_addr, 32'h0);
    bus.i_pc_counter_en = 1'b1;
    step("pc_inc");
    clear_inputs();
    #1;
    check("mem_ar", bus.o_mem_read_addr, 32'h0);
    bus.i_read_addr_source = 1'b1;
    #1;
    check("mem_pc", bus.o_mem_read_addr, 32'h1);

    // PC write/increment collision
    clear_inputs();
    bus.i_pc_we = 1'b1; bus.i_pc_counter_en = 1'b1; bus.i_data = 16'h0040;
    step("coll");
    clear_inputs();
    #1;
    check("coll_pc", bus.o_program_addr, 32'h0040);
    check("coll_flag", bus.o_err_collision, 32'h1);
    step("coll_hold");
    check("coll_sticky", bus.o_err_collision, 32'h1);
    bus.i_err_clr = 1'b1;
    step("coll_clr");
    clear_inputs();
    #1;
    check("coll_cleared", bus.o_err_collision, 32'h0);

    // Stall holds everything, then updates resume
    bus.i_stall = 1'b1; bus.i_ar_we = 1'b1; bus.i_pc_we = 1'b1;
    bus.i_ar_post_inc = 1'b1; bus.i_pc_counter_en = 1'b1;
    bus.i_dr_we = 4'hF; bus.i_data = 16'hA5A5; bus.i_op0_sel = 2'd2;
    repeat (3) step("stall");
    #1;
    check("stall_ar", bus.o_direct_addr, 32'h0);
    check("stall_pc", bus.o_program_addr, 32'h0040);
    check("stall_dr2", bus.o_operand0, 32'hBEEF);
    check("stall_ecol", bus.o_err_collision, 32'h0);
    bus.i_stall = 1'b0;
    step("unstall");
    clear_inputs();
    bus.i_op0_sel = 2'd2;
    #1;
    check("resume_ar", bus.o_direct_addr, 32'hA5A5);
    check("resume_pc", bus.o_program_addr, 32'hA5A5);
    check("resume_dr2", bus.o_operand0, 32'hA5A5);
    check("resume_ecol", bus.o_err_collision, 32'h1);

    // Multi-hot output select
    clear_inputs();
    bus.i_ar_we = 1'b1; bus.i_data = 16'h00F0;
    step("ld_f0");
    clear_inputs();
    bus.i_dr_we = 4'b0001; bus.i_data = 16'h000F;
    step("ld_0f");
    clear_inputs();
    bus.i_err_clr = 1'b1;
    step("clr_all");
    clear_inputs();
    bus.i_out_en = 6'b000011;
    #1;
    check("multi_rout", bus.o_register_output, 32'h00FF);
    check("multi_pre", bus.o_err_out_multi, 32'h0);
    step("multi");
    check("multi_post", bus.o_err_out_multi, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.i_data             = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.i_ar_we            = ($urandom_range(0, 3) == 0);
      bus.i_pc_we            = ($urandom_range(0, 3) == 0);
      bus.i_ar_post_inc      = ($urandom_range(0, 1) == 0);
      bus.i_pc_counter_en    = ($urandom_range(0, 1) == 0);
      bus.i_dr_we            = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.i_stall            = ($urandom_range(0, 4) == 0);
      bus.i_out_en           = ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom_range(0, 63));
      bus.i_op0_sel          = 2'($urandom_range(0, 3));
      bus.i_op1_sel          = 2'($urandom_range(0, 3));
      bus.i_read_addr_source = 1'($urandom_range(0, 1));
      bus.i_err_clr          = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) mid_reset();
      else step("rnd");
    end
    #1;
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_register_bank.md
Name: data_register_bank

Overview:
- Parametrised successor to the core's fixed AR/DR0/DR1 + PC register controller.
- Holds one address register (AR), NUM_DR data registers (DR[0..NUM_DR-1]) and the program counter (PC).
- Adds indexed operand selection, AR post-increment, PC auto-increment with write priority, global stall, and sticky protocol-error flags.
- Sits between the instruction decoder/sequencer (enables) and the ALU and memory (operands, addresses).

Parameters:
- DATA_WIDTH, 16, width of every register and data path.
- NUM_DR, 4, number of data registers; legal range 2..16.
- IDX_W, 2, operand index width; must equal clog2(NUM_DR).
- AR_STRIDE, 1, AR post-increment amount.
- PC_STRIDE, 1, PC auto-increment amount.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_data  in  DATA_WIDTH  write data shared by all registers.
- i_ar_we  in  1  load AR from i_data.
- i_dr_we  in  NUM_DR  per-register load enables for DR.
- i_pc_we  in  1  load PC from i_data (jump).
- i_ar_post_inc  in  1  AR += AR_STRIDE.
- i_pc_counter_en  in  1  PC += PC_STRIDE.
- i_stall  in  1  freeze all register updates.
- i_out_en  in  NUM_DR+2  one-hot output select: bit0 AR, bits1..NUM_DR DR[k-1], bit NUM_DR+1 PC.
- i_op0_sel  in  IDX_W  DR index driving o_operand0.
- i_op1_sel  in  IDX_W  DR index driving o_operand1.
- i_read_addr_source  in  1  1 selects PC, 0 selects AR, for o_mem_read_addr.
- i_err_clr  in  1  clear the sticky error flags.
- o_direct_addr  out  DATA_WIDTH  AR.
- o_operand0  out  DATA_WIDTH  DR[i_op0_sel].
- o_operand1  out  DATA_WIDTH  DR[i_op1_sel].
- o_register_output  out  DATA_WIDTH  OR of all enabled registers.
- o_mem_read_addr  out  DATA_WIDTH  PC or AR, per i_read_addr_source.
- o_program_addr  out  DATA_WIDTH  PC.
- o_err_out_multi  out  1  sticky; set when i_out_en had more than one bit set.
- o_err_collision  out  1  sticky; set when a write and an increment hit the same register in one cycle.

Behaviour:
- Reset (async, rst_n low): AR=0, all DR=0, PC=PC_RESET, both error flags 0. All outputs take these values immediately, without waiting for a clock edge.
- Registers update on the rising edge of clk only when i_stall=0. While i_stall=1, every register holds, including through increment requests.
- Error flags are not affected by i_stall.
- AR next value, in priority order:
  - i_ar_we: load i_data.
  - else i_ar_post_inc: AR + AR_STRIDE, modulo 2^DATA_WIDTH (wraps; no saturation).
  - else hold.
- PC next value, in priority order:
  - i_pc_we: load i_data.
  - else i_pc_counter_en: PC + PC_STRIDE, modulo 2^DATA_WIDTH.
  - else hold.
- DR[k] loads i_data when i_dr_we[k]=1. Several DRs may load the same i_data in one cycle.
- Collision rule: (i_ar_we & i_ar_post_inc) or (i_pc_we & i_pc_counter_en) with i_stall=0 means the write wins, and o_err_collision is set on that edge.
- Combinational outputs, zero latency from register state:
  - o_register_output is the OR-reduction of the selected registers; it is 0 when i_out_en=0.
  - More than one bit set in i_out_en still produces the OR value, and sets o_err_out_multi on the next edge.
- Operand index >= NUM_DR (only possible when NUM_DR is not a power of two) returns 0.
- Write-then-read: a value written on edge n is visible on every output from edge n onward. There is no write-through bypass within the same cycle.
- Error flags:
  - Both are sticky until i_err_clr=1 at an edge.
  - If a clear and a new error occur on the same edge, the flag stays set (set wins).
- Reset asserted mid-operation overrides all pending writes and increments immediately.

Decomposition:
- Shared package (core defines): DATA_WIDTH default, output-select bit positions (OUT_AR=0, OUT_DR_BASE=1, OUT_PC=NUM_DR+1), PC_RESET default.
- Sub-module pc_unit:
  - Holds the PC register.
  - Implements write/increment priority and stall.
  - Reports the collision condition.
  - Instantiated once.
- The AR and DR array stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with AR=0x1234 -> all outputs 0 and o_program_addr=PC_RESET before the next clk edge.
- Load/select: write DR2=0xBEEF and DR0=0x0011, set op0_sel=2, op1_sel=0 -> o_operand0=0xBEEF, o_operand1=0x0011. Then i_out_en=0b001000 -> o_register_output=0xBEEF.
- Wrap: AR=0xFFFF, i_ar_post_inc -> AR=0x0000. PC=0xFFFF, i_pc_counter_en -> PC=0x0000. i_read_addr_source toggles o_mem_read_addr between the two.
- Collision: i_pc_we=1 with i_data=0x0040 and i_pc_counter_en=1 in the same cycle -> PC=0x0040 and o_err_collision=1. It stays 1 until i_err_clr, then reads 0.
- Stall: i_stall=1 with all write/inc enables high for 3 cycles -> no register changes. Deassert -> updates resume on the next edge.
- Multi-hot select: i_out_en=0b000011 with AR=0x00F0, DR0=0x000F -> o_register_output=0x00FF, o_err_out_multi=1 after the edge.
